// File: rtl/mtimer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare register and
// level interrupt. mtime_hi reads come from a shadow latched on mtime_lo reads.
module mtimer #(
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        intr_timer
);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_PRESCALE = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        en_q, en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        intr_q, intr_d;

  logic [2:0]  idx_s;
  logic        wr_s;
  logic        rd_s;
  logic        unused_addr_s;

  assign idx_s         = addr[4:2];
  assign wr_s          = sel & we;
  assign rd_s          = sel & ~we;
  assign unused_addr_s = ^addr[1:0];

  // Next-state: prescaled increment first, bus writes override it afterwards.
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    prescale_d  = prescale_q;
    pcnt_d      = pcnt_q;
    hi_shadow_d = hi_shadow_q;
    en_d        = en_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    intr_d      = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = 16'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d  = pcnt_q + 16'd1;
      end
    end else begin
      pcnt_d = pcnt_q;
    end

    if (wr_s) begin
      case (idx_s)
        IDX_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], wdata};
          pcnt_d  = 16'd0;
        end
        IDX_MTIME_HI: begin
          mtime_d = {wdata, mtime_q[31:0]};
          pcnt_d  = 16'd0;
        end
        IDX_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
        IDX_CMP_HI:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        IDX_CTRL:     en_d = wdata[0];
        IDX_PRESCALE: begin
          prescale_d = wdata[15:0];
          pcnt_d     = 16'd0;
        end
        default: ;
      endcase
    end else begin
      en_d = en_q;
    end

    // Reading the low half snapshots the high half for a coherent 64-bit read.
    if (rd_s) begin
      rvalid_d = 1'b1;
      case (idx_s)
        IDX_MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        IDX_MTIME_HI: rdata_d = hi_shadow_q;
        IDX_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        IDX_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        IDX_CTRL:     rdata_d = {31'd0, en_q};
        IDX_PRESCALE: rdata_d = {16'd0, prescale_q};
        default:      rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescale_q  <= PRESCALE_RST;
      pcnt_q      <= 16'd0;
      hi_shadow_q <= 32'd0;
      en_q        <= 1'b0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      prescale_q  <= prescale_d;
      pcnt_q      <= pcnt_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      intr_q      <= intr_d;
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign intr_timer = intr_q;

endmodule
